hc_responder: RTL and testbench
===============================

Name: hc_responder

Overview:
Receive-side counterpart of the CCI-P requestor.
- Consumes read responses on ccip_rx channel 0 and write completions on channel 1.
- Steers each read-response cache line into a per-buffer RX FIFO selected by the mdata tag the requestor stamped on the request.
- Tracks outstanding read and write transactions and raises done once a finished run has fully drained.
- Sits between the CCI-P shim and the core, beside the requestor.

Parameters:
HC_RX_BUFFERS, 4, number of RX buffers/FIFOs; mdata[$clog2(HC_RX_BUFFERS)-1:0] selects the buffer.
HC_RX_DEPTH, 64, entries per RX FIFO, power of two.
HC_MAX_OUTSTANDING, 256, read-credit limit; rd_credit deasserts at this count.
HC_CNT_W, 16, width of the outstanding counters.

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous, active-low
start  in  1  level, run enabled (registered start from requestor)
finish  in  1  core has issued its last request
ccip_rx  in  t_if_ccip_Rx  CCI-P receive struct (c0/c1 response channels)
rd_req_issued  in  1  pulse; one c0 read request sent this cycle
wr_req_issued  in  1  pulse; one c1 write request sent this cycle
rx_data  out  HC_RX_BUFFERS x 512  per-buffer FIFO head data
rx_valid  out  HC_RX_BUFFERS  per-buffer FIFO not empty
rx_ready  in  HC_RX_BUFFERS  per-buffer dequeue when rx_valid & rx_ready
rd_credit  out  1  1 when rd_outstanding < HC_MAX_OUTSTANDING
rd_outstanding  out  HC_CNT_W  reads issued minus reads answered
wr_outstanding  out  HC_CNT_W  writes issued minus writes acknowledged
done  out  1  high in S_DONE
err_overflow  out  1  sticky; read response dropped because the target FIFO was full
err_bad_id  out  1  sticky; mdata id >= HC_RX_BUFFERS, response dropped
err_underflow  out  1  sticky; response received with the outstanding count at 0

Behaviour:
Reset:
- All outputs 0, except rd_credit=1.
- FIFOs empty; FSM in S_IDLE.
- Reset asserted mid-run discards FIFO contents and counters immediately.

Read path:
- A read response is accepted when c0.rspValid=1 and the header type is a read response.
- Accepted data is registered and enqueued; rx_valid rises the cycle after rspValid (1-cycle latency).
- FIFOs are show-ahead: rx_data is valid whenever rx_valid=1.
- Enqueue and dequeue on the same FIFO in the same cycle, even when full, keeps occupancy unchanged and no data is lost.
- CCI-P cannot be backpressured. If the target FIFO is full: drop the line, set err_overflow, still decrement rd_outstanding.
- Bad id: drop the line, set err_bad_id, still decrement rd_outstanding.
- Per-buffer ordering is arrival order; no reordering is performed.

Counters:
- rd_outstanding: +1 on rd_req_issued, -1 on each accepted read response; both in the same cycle leaves it unchanged.
- wr_outstanding: +1 on wr_req_issued; on c1.rspValid, subtract cl_num+1 (packed completions), otherwise 1.
- Counters saturate at 0: a decrement at 0 leaves 0 and sets err_underflow.
- Counters saturate at the all-ones value, with no wrap.
- rd_credit is combinational from the registered rd_outstanding.

FSM (registered state):
- S_IDLE -> S_RUN when start=1.
- S_RUN -> S_DRAIN when finish=1.
- S_DRAIN -> S_DONE when rd_outstanding=0, wr_outstanding=0, and all rx_valid=0.
- S_DONE -> S_IDLE when start=0.
- Responses are processed in every state. Responses arriving in S_IDLE or S_DONE are counted as underflow if no transaction is outstanding.
- done=1 only in S_DONE, asserted the cycle after the drain condition holds.
- If start and finish arrive together in S_IDLE: go to S_RUN first, then S_DRAIN on the next cycle.

Optional Feature:
Macro: HC_RESPONDER_STATS_EN.
- Defined: adds outputs stat_rd_rsp, stat_wr_rsp, and stat_drop, each 32 bits.
  - stat_rd_rsp and stat_wr_rsp are free-running counts of accepted c0 and c1 responses.
  - stat_drop counts lines lost to overflow or bad id.
  - All three clear on reset and when leaving S_IDLE; they wrap modulo 2^32.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start=1 and 8 rd_req_issued pulses; 8 responses with mdata=2 and data=i -> rx_valid[2] rises 1 cycle after the first response; data 0..7 in order; rd_outstanding returns to 0.
- Hold rx_ready[0]=0 and send 65 responses to buffer 0 (depth 64) -> 64 stored, err_overflow=1, rd_outstanding=0.
- Send mdata=5 with HC_RX_BUFFERS=4 -> no rx_valid, err_bad_id=1, rd_outstanding decremented.
- In the same cycle, rd_req_issued=1 and a read response arrives, with rd_outstanding=3 -> stays 3. Separately, a packed c1 completion with cl_num=3 and wr_outstanding=4 -> 0.
- Issue 256 reads with no responses -> rd_credit=0; one response -> rd_credit=1 the next cycle.
- finish=1 with 2 reads outstanding and 1 line queued -> done stays 0; after the responses arrive and all lines are dequeued, done=1 the following cycle; start=0 -> S_IDLE and done=0.

Source files
------------

// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P receive-side types: c0 read responses and c1 write completions.
package ccip_if_pkg;

  localparam int unsigned CCIP_CLDATA_W = 512;
  localparam int unsigned CCIP_MDATA_W  = 16;

  localparam logic [3:0] RSP_RDLINE = 4'h0;

  typedef struct packed {
    logic [1:0]              vc_used;
    logic                    rsvd1;
    logic                    hit_miss;
    logic [1:0]              rsvd0;
    logic [1:0]              cl_num;
    logic [3:0]              resp_type;
    logic [CCIP_MDATA_W-1:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]              vc_used;
    logic                    rsvd1;
    logic                    hit_miss;
    logic                    format;
    logic                    rsvd0;
    logic [1:0]              cl_num;
    logic [3:0]              resp_type;
    logic [CCIP_MDATA_W-1:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr       hdr;
    logic [CCIP_CLDATA_W-1:0] data;
    logic                     rspValid;
    logic                     mmioRdValid;
    logic                     mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

endpackage

// File: rtl/hc_responder.sv
// CCI-P response side: steers read lines into per-buffer FIFOs, tracks outstanding
// reads/writes, signals done after drain. Optional counters: HC_RESPONDER_STATS_EN.
module hc_responder
  import ccip_if_pkg::*;
#(
  parameter int unsigned HC_RX_BUFFERS      = 4,
  parameter int unsigned HC_RX_DEPTH        = 64,
  parameter int unsigned HC_MAX_OUTSTANDING = 256,
  parameter int unsigned HC_CNT_W           = 16
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         start,
  input  logic                                         finish,
  input  t_if_ccip_Rx                                  ccip_rx,
  input  logic                                         rd_req_issued,
  input  logic                                         wr_req_issued,
  output logic [HC_RX_BUFFERS-1:0][CCIP_CLDATA_W-1:0]  rx_data,
  output logic [HC_RX_BUFFERS-1:0]                     rx_valid,
  input  logic [HC_RX_BUFFERS-1:0]                     rx_ready,
  output logic                                         rd_credit,
  output logic [HC_CNT_W-1:0]                          rd_outstanding,
  output logic [HC_CNT_W-1:0]                          wr_outstanding,
  output logic                                         done,
  output logic                                         err_overflow,
  output logic                                         err_bad_id,
  output logic                                         err_underflow
`ifdef HC_RESPONDER_STATS_EN
  ,
  output logic [31:0]                                  stat_rd_rsp,
  output logic [31:0]                                  stat_wr_rsp,
  output logic [31:0]                                  stat_drop
`endif
);

  localparam int unsigned ID_W  = (HC_RX_BUFFERS > 1) ? $clog2(HC_RX_BUFFERS) : 1;
  localparam int unsigned AW    = $clog2(HC_RX_DEPTH);
  localparam int unsigned EXT_W = HC_CNT_W + 1;
  localparam logic [HC_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(HC_RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_d;

  logic                     rd_rsp;
  logic                     id_ok;
  logic [ID_W-1:0]          rsp_id;
  logic                     drop_ovf;
  logic                     drop_bad;
  logic [HC_RX_BUFFERS-1:0] fifo_full;
  logic [HC_RX_BUFFERS-1:0] fifo_enq;
  logic                     drained;
  logic                     unused_ok;

  logic [EXT_W-1:0]    rd_sum, wr_sum, rd_dif, wr_dif;
  logic [2:0]          wr_dec;
  logic [HC_CNT_W-1:0] rd_cnt_d, wr_cnt_d;
  logic                rd_uf, wr_uf;

  // Only read-line responses count; the full mdata must name a real buffer.
  assign rd_rsp    = ccip_rx.c0.rspValid && (ccip_rx.c0.hdr.resp_type == RSP_RDLINE);
  assign id_ok     = ccip_rx.c0.hdr.mdata < CCIP_MDATA_W'(HC_RX_BUFFERS);
  assign rsp_id    = ccip_rx.c0.hdr.mdata[ID_W-1:0];
  assign drop_bad  = rd_rsp & ~id_ok;
  assign drop_ovf  = rd_rsp & id_ok & fifo_full[rsp_id];
  assign unused_ok = ^{ccip_rx};

  // Per-buffer show-ahead FIFO; a same-cycle dequeue frees the slot for the enqueue.
  for (genvar b = 0; b < HC_RX_BUFFERS; b++) begin : g_fifo
    logic [CCIP_CLDATA_W-1:0] mem [HC_RX_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count;
    logic                     deq;

    assign rx_valid[b]  = (count != '0);
    assign deq          = rx_valid[b] & rx_ready[b];
    assign fifo_full[b] = (count == FULL_CNT) & ~deq;
    assign fifo_enq[b]  = rd_rsp & id_ok & (rsp_id == ID_W'(b)) & ~fifo_full[b];
    assign rx_data[b]   = rx_valid[b] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (fifo_enq[b]) mem[wr_ptr] <= ccip_rx.c0.data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (fifo_enq[b]) wr_ptr <= wr_ptr + AW'(1);
        if (deq)         rd_ptr <= rd_ptr + AW'(1);
        case ({fifo_enq[b], deq})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Outstanding counters: clamp at zero (flagging underflow) and at all-ones.
  always_comb begin
    wr_dec   = 3'd0;
    rd_uf    = 1'b0;
    wr_uf    = 1'b0;
    rd_cnt_d = rd_outstanding;
    wr_cnt_d = wr_outstanding;
    if (ccip_rx.c1.rspValid) begin
      wr_dec = ccip_rx.c1.hdr.format ? ({1'b0, ccip_rx.c1.hdr.cl_num} + 3'd1) : 3'd1;
    end
    rd_sum = {1'b0, rd_outstanding} + EXT_W'(rd_req_issued);
    wr_sum = {1'b0, wr_outstanding} + EXT_W'(wr_req_issued);
    rd_dif = rd_sum - EXT_W'(rd_rsp);
    wr_dif = wr_sum - EXT_W'(wr_dec);
    if (rd_sum < EXT_W'(rd_rsp)) begin
      rd_uf    = 1'b1;
      rd_cnt_d = '0;
    end else begin
      rd_cnt_d = rd_dif[HC_CNT_W] ? CNT_MAX : rd_dif[HC_CNT_W-1:0];
    end
    if (wr_sum < EXT_W'(wr_dec)) begin
      wr_uf    = 1'b1;
      wr_cnt_d = '0;
    end else begin
      wr_cnt_d = wr_dif[HC_CNT_W] ? CNT_MAX : wr_dif[HC_CNT_W-1:0];
    end
  end

  assign rd_credit = {1'b0, rd_outstanding} < EXT_W'(HC_MAX_OUTSTANDING);
  assign drained   = (rd_outstanding == '0) && (wr_outstanding == '0) && (rx_valid == '0);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start)   state_d = S_RUN;
      S_RUN:   if (finish)  state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_DONE;
      S_DONE:  if (!start)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      done           <= 1'b0;
      rd_outstanding <= '0;
      wr_outstanding <= '0;
      err_overflow   <= 1'b0;
      err_bad_id     <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      state          <= state_d;
      done           <= (state_d == S_DONE);
      rd_outstanding <= rd_cnt_d;
      wr_outstanding <= wr_cnt_d;
      err_overflow   <= err_overflow | drop_ovf;
      err_bad_id     <= err_bad_id | drop_bad;
      err_underflow  <= err_underflow | rd_uf | wr_uf;
    end
  end

`ifdef HC_RESPONDER_STATS_EN
  logic leave_idle;
  assign leave_idle = (state == S_IDLE) && (state_d != S_IDLE);

  // Run statistics restart each time a new run leaves idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_rsp <= '0;
      stat_wr_rsp <= '0;
      stat_drop   <= '0;
    end else if (leave_idle) begin
      stat_rd_rsp <= '0;
      stat_wr_rsp <= '0;
      stat_drop   <= '0;
    end else begin
      stat_rd_rsp <= stat_rd_rsp + 32'(rd_rsp);
      stat_wr_rsp <= stat_wr_rsp + 32'(ccip_rx.c1.rspValid);
      stat_drop   <= stat_drop + 32'(drop_ovf | drop_bad);
    end
  end
`endif

endmodule

// File: tb/tb_hc_responder.sv
// Bench for hc_responder: directed plan steps plus a random phase against a queue model.
module tb_hc_responder;
  import ccip_if_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 64;
  localparam int MAXO  = 256;
  localparam int CMAX  = 65535;
  localparam logic [3:0] RSP_UMSG = 4'h4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start, finish, rd_req_issued, wr_req_issued;
  t_if_ccip_Rx ccip_rx;
  logic [NB-1:0][511:0] rx_data;
  logic [NB-1:0] rx_valid, rx_ready;
  logic rd_credit, done, err_overflow, err_bad_id, err_underflow;
  logic [15:0] rd_outstanding, wr_outstanding;
`ifdef HC_RESPONDER_STATS_EN
  logic [31:0] stat_rd_rsp, stat_wr_rsp, stat_drop;
`endif

  always #5 clk = ~clk;

  hc_responder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish), .ccip_rx(ccip_rx),
    .rd_req_issued(rd_req_issued), .wr_req_issued(wr_req_issued),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rd_credit(rd_credit), .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .done(done), .err_overflow(err_overflow), .err_bad_id(err_bad_id),
    .err_underflow(err_underflow)
`ifdef HC_RESPONDER_STATS_EN
    , .stat_rd_rsp(stat_rd_rsp), .stat_wr_rsp(stat_wr_rsp), .stat_drop(stat_drop)
`endif
  );

  // Reference model: one queue per buffer, plain integer counters, 0..3 = idle/run/drain/done.
  logic [511:0] mq [NB][$];
  int m_rd, m_wr, m_state;
  logic m_ovf, m_bad, m_uf;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit model_busy();
    bit busy = (m_rd != 0) || (m_wr != 0);
    for (int b = 0; b < NB; b++) if (mq[b].size() != 0) busy = 1'b1;
    return busy;
  endfunction

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_state = 0;
    m_ovf = 1'b0; m_bad = 1'b0; m_uf = 1'b0;
    for (int b = 0; b < NB; b++) mq[b].delete();
  endtask

  // Apply one clock edge worth of behaviour from the current inputs.
  task automatic model_step();
    bit pop [NB];
    bit drained;
    int id, dec, nrd, nwr, md;
    if (!reset_n) return;
    drained = !model_busy();
    case (m_state)
      0: if (start)   m_state = 1;
      1: if (finish)  m_state = 2;
      2: if (drained) m_state = 3;
      default: if (!start) m_state = 0;
    endcase
    for (int b = 0; b < NB; b++) pop[b] = (mq[b].size() > 0) && rx_ready[b];
    dec = 0; id = -1;
    if (ccip_rx.c0.rspValid && ccip_rx.c0.hdr.resp_type == RSP_RDLINE) begin
      dec = 1;
      md = int'(ccip_rx.c0.hdr.mdata);
      if (md >= NB) m_bad = 1'b1;
      else if (mq[md].size() == DEPTH && !pop[md]) m_ovf = 1'b1;
      else id = md;
    end
    for (int b = 0; b < NB; b++) if (pop[b]) void'(mq[b].pop_front());
    if (id >= 0) mq[id].push_back(ccip_rx.c0.data);
    nrd = m_rd + int'(rd_req_issued) - dec;
    if (nrd < 0) begin nrd = 0; m_uf = 1'b1; end
    if (nrd > CMAX) nrd = CMAX;
    dec = 0;
    if (ccip_rx.c1.rspValid) dec = ccip_rx.c1.hdr.format ? int'(ccip_rx.c1.hdr.cl_num) + 1 : 1;
    nwr = m_wr + int'(wr_req_issued) - dec;
    if (nwr < 0) begin nwr = 0; m_uf = 1'b1; end
    if (nwr > CMAX) nwr = CMAX;
    m_rd = nrd; m_wr = nwr;
  endtask

  task automatic check_all();
    logic [NB-1:0] ev;
    for (int b = 0; b < NB; b++) ev[b] = (mq[b].size() > 0);
    chk("rx_valid", 32'(rx_valid), 32'(ev));
    for (int b = 0; b < NB; b++)
      if (ev[b]) chk_line($sformatf("rx_data[%0d]", b), rx_data[b], mq[b][0]);
    chk("rd_outstanding", 32'(rd_outstanding), m_rd);
    chk("wr_outstanding", 32'(wr_outstanding), m_wr);
    chk("rd_credit", 32'(rd_credit), (m_rd < MAXO) ? 32'd1 : 32'd0);
    chk("done", 32'(done), (m_state == 3) ? 32'd1 : 32'd0);
    chk("err_flags", 32'({err_overflow, err_bad_id, err_underflow}), 32'({m_ovf, m_bad, m_uf}));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    check_all();
    rd_req_issued = 1'b0;
    wr_req_issued = 1'b0;
    ccip_rx.c0.rspValid = 1'b0;
    ccip_rx.c1.rspValid = 1'b0;
  endtask

  task automatic send_rd(input int id, input logic [511:0] d);
    ccip_rx.c0.rspValid = 1'b1;
    ccip_rx.c0.hdr.resp_type = RSP_RDLINE;
    ccip_rx.c0.hdr.mdata = 16'(id);
    ccip_rx.c0.data = d;
  endtask

  task automatic send_wr(input bit fmt, input int cl);
    ccip_rx.c1.rspValid = 1'b1;
    ccip_rx.c1.hdr.format = fmt;
    ccip_rx.c1.hdr.cl_num = 2'(cl);
  endtask

  initial begin
    int n, r, cl;
    bit fmt;
    ccip_rx = '0; rx_ready = '0; start = 1'b0; finish = 1'b0;
    rd_req_issued = 1'b0; wr_req_issued = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) tick();
    for (int b = 0; b < NB; b++) chk_line("reset_rx_data", rx_data[b], '0);
    reset_n = 1'b1;
    tick();

    // Eight reads answered into buffer 2, then drained in order.
    start = 1'b1; tick();
    repeat (8) begin rd_req_issued = 1'b1; tick(); end
    chk("t1_issued", 32'(rd_outstanding), 32'd8);
    for (int i = 0; i < 8; i++) begin
      send_rd(2, 512'(i)); tick();
      if (i == 0) chk("t1_latency", 32'(rx_valid[2]), 32'd1);
    end
    chk("t1_rd_zero", 32'(rd_outstanding), 32'd0);
    rx_ready[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_line("t1_order", rx_data[2], 512'(i)); tick();
    end
    rx_ready = '0;

    // 65 lines into a 64-deep buffer with no dequeue.
    repeat (65) begin rd_req_issued = 1'b1; tick(); end
    repeat (65) begin send_rd(0, rand_line()); tick(); end
    chk("t2_overflow", 32'(err_overflow), 32'd1);
    chk("t2_rd_zero", 32'(rd_outstanding), 32'd0);
    rx_ready[0] = 1'b1; n = 0;
    while (rx_valid[0] && n < 100) begin tick(); n++; end
    chk("t2_stored", n, 32'd64);
    rx_ready = '0;

    // Out-of-range id.
    rd_req_issued = 1'b1; tick();
    send_rd(5, rand_line()); tick();
    chk("t3_no_valid", 32'(rx_valid), 32'd0);
    chk("t3_bad_id", 32'(err_bad_id), 32'd1);
    chk("t3_rd_dec", 32'(rd_outstanding), 32'd0);

    // Simultaneous issue and response; packed write completion.
    repeat (3) begin rd_req_issued = 1'b1; tick(); end
    rd_req_issued = 1'b1; send_rd(1, rand_line()); tick();
    chk("t4_rd_same", 32'(rd_outstanding), 32'd3);
    repeat (3) begin send_rd(1, rand_line()); tick(); end
    rx_ready[1] = 1'b1; repeat (4) tick(); rx_ready = '0;
    repeat (4) begin wr_req_issued = 1'b1; tick(); end
    chk("t4_wr_four", 32'(wr_outstanding), 32'd4);
    send_wr(1'b1, 3); tick();
    chk("t4_wr_packed", 32'(wr_outstanding), 32'd0);
    chk("t4_no_uf", 32'(err_underflow), 32'd0);

    // Credit limit.
    repeat (256) begin rd_req_issued = 1'b1; tick(); end
    chk("t5_credit_off", 32'(rd_credit), 32'd0);
    rx_ready[3] = 1'b1;
    send_rd(3, rand_line()); tick();
    chk("t5_credit_on", 32'(rd_credit), 32'd1);
    repeat (255) begin send_rd(3, rand_line()); tick(); end
    tick();
    chk("t5_rd_zero", 32'(rd_outstanding), 32'd0);
    rx_ready = '0;

    // Random traffic without underflow.
    for (int c = 0; c < 400; c++) begin
      rd_req_issued = (m_rd < 200) && ($urandom_range(0, 1) == 1);
      wr_req_issued = ($urandom_range(0, 1) == 1);
      rx_ready = 4'($urandom);
      if (m_rd > 0 && $urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 15);
        send_rd((r < 12) ? (r % 4) : (4 + r % 4), rand_line());
        if ($urandom_range(0, 7) == 0) ccip_rx.c0.hdr.resp_type = RSP_UMSG;
      end
      if (m_wr > 0 && $urandom_range(0, 1) == 1) begin
        fmt = ($urandom_range(0, 1) == 1);
        cl = fmt ? $urandom_range(0, (m_wr > 4) ? 3 : m_wr - 1) : 0;
        send_wr(fmt, cl);
      end
      tick();
    end

    rx_ready = '1; n = 0;
    while (model_busy() && n < 2000) begin
      if (m_rd > 0) send_rd($urandom_range(0, 3), rand_line());
      if (m_wr > 0) send_wr(1'b0, 0);
      tick(); n++;
    end
    chk("drain_rd", 32'(rd_outstanding), 32'd0);
    chk("drain_wr", 32'(wr_outstanding), 32'd0);
    chk("drain_valid", 32'(rx_valid), 32'd0);
    rx_ready = '0;

    // Done only after outstanding reads and queued lines are gone.
    repeat (3) begin rd_req_issued = 1'b1; tick(); end
    send_rd(1, rand_line()); tick();
    finish = 1'b1; tick();
    chk("t6_drain_wait", 32'(done), 32'd0);
    repeat (3) tick();
    chk("t6_still_wait", 32'(done), 32'd0);
    repeat (2) begin send_rd(1, rand_line()); tick(); end
    chk("t6_lines_queued", 32'(done), 32'd0);
    rx_ready[1] = 1'b1; repeat (3) tick();
    chk("t6_empty", 32'(rx_valid), 32'd0);
    chk("t6_done_not_yet", 32'(done), 32'd0);
    tick();
    chk("t6_done", 32'(done), 32'd1);
    start = 1'b0; finish = 1'b0; rx_ready = '0; tick();
    chk("t6_idle", 32'(done), 32'd0);

    // start and finish together from idle.
    start = 1'b1; finish = 1'b1; tick();
    chk("t7_run", 32'(done), 32'd0);
    tick();
    chk("t7_drain", 32'(done), 32'd0);
    tick();
    chk("t7_done", 32'(done), 32'd1);
    start = 1'b0; finish = 1'b0; tick();
    chk("t7_idle", 32'(done), 32'd0);

    // Completion with nothing outstanding.
    chk("t8_uf_before", 32'(err_underflow), 32'd0);
    send_wr(1'b0, 0); tick();
    chk("t8_uf", 32'(err_underflow), 32'd1);
    chk("t8_wr_floor", 32'(wr_outstanding), 32'd0);

    // Asynchronous reset mid-run.
    start = 1'b1; tick();
    repeat (2) begin rd_req_issued = 1'b1; tick(); end
    send_rd(0, rand_line()); tick();
    wr_req_issued = 1'b1; tick();
    #3 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("t9_valid_cleared", 32'(rx_valid), 32'd0);
    chk("t9_credit", 32'(rd_credit), 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
